// File: rtl/user_io_pkg.sv
// Shared definitions for the I2C GPIO expander target: FSM states, register
// addresses, reset values and the register read mux.
package user_io_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [2:0] REG_IN0  = 3'd0;
  localparam logic [2:0] REG_IN1  = 3'd1;
  localparam logic [2:0] REG_OUT0 = 3'd2;
  localparam logic [2:0] REG_OUT1 = 3'd3;
  localparam logic [2:0] REG_POL0 = 3'd4;
  localparam logic [2:0] REG_POL1 = 3'd5;
  localparam logic [2:0] REG_CFG0 = 3'd6;
  localparam logic [2:0] REG_CFG1 = 3'd7;

  localparam logic [15:0] OUT_RST = 16'hFFFF;
  localparam logic [15:0] POL_RST = 16'h0000;
  localparam logic [15:0] CFG_RST = 16'hFFFF;

  // Even pointers select the low byte (port 0), odd pointers the high byte.
  function automatic logic [7:0] reg_read(input logic [2:0]  ptr,
                                          input logic [15:0] pins,
                                          input logic [15:0] out_r,
                                          input logic [15:0] pol_r,
                                          input logic [15:0] cfg_r);
    logic [15:0] word;
    case (ptr[2:1])
      2'd0:    word = pins ^ pol_r;
      2'd1:    word = out_r;
      2'd2:    word = pol_r;
      default: word = cfg_r;
    endcase
    return ptr[0] ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchronizer, 3-sample majority filter and
// detection of SCL edges plus START/STOP on the filtered lines.
module i2c_line_cond #(
  parameter int CLK_RATE_HZ = 16_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // Filter samples are spaced at least 50 ns apart so a single sample spike is rejected.
  localparam int SAMPLE_DIV = (CLK_RATE_HZ + 19_999_999) / 20_000_000;
  localparam int DIV_W      = $clog2(SAMPLE_DIV + 1);

  logic [DIV_W-1:0] div_cnt;
  logic             sample_en;
  logic             scl_p0, scl_p1, sda_p0, sda_p1;
  logic [2:0]       scl_win, sda_win;
  logic             scl_f, sda_f, scl_prev, sda_prev;

  function automatic logic maj3(input logic [2:0] w);
    return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endfunction

  assign sample_en = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt  <= '0;
      scl_p0   <= 1'b1;
      scl_p1   <= 1'b1;
      sda_p0   <= 1'b1;
      sda_p1   <= 1'b1;
      scl_win  <= 3'b111;
      sda_win  <= 3'b111;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // stage p0/p1: metastability synchronizer
      scl_p0   <= i_scl;
      scl_p1   <= scl_p0;
      sda_p0   <= i_sda;
      sda_p1   <= sda_p0;
      div_cnt  <= sample_en ? '0 : div_cnt + DIV_W'(1);
      if (sample_en) begin
        scl_win <= {scl_win[1:0], scl_p1};
        sda_win <= {sda_win[1:0], sda_p1};
      end
      // filtered level and its previous value for edge detection
      scl_f    <= maj3(scl_win);
      sda_f    <= maj3(sda_win);
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  assign sda      = sda_f;
  assign scl_rise = scl_f & ~scl_prev;
  assign scl_fall = ~scl_f & scl_prev;
  assign start    = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop     = scl_f & scl_prev & ~sda_prev & sda_f;

endmodule

// File: rtl/i2c_expander_target.sv
// I2C target exposing a 16-bit GPIO expander: input, output, polarity and
// configuration register pairs behind an auto-toggling byte pointer.
module i2c_expander_target
  import user_io_pkg::*;
#(
  parameter logic [6:0] SADR        = 7'b0100_000,
  parameter int         CLK_RATE_HZ = 16_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_sda_t,
  input  logic [15:0] i_pins,
  output logic [15:0] o_pins,
  output logic [15:0] o_oe,
  output logic        o_busy
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_cond #(
    .CLK_RATE_HZ(CLK_RATE_HZ)
  ) u_line_cond (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_scl   (i_scl),
    .i_sda   (i_sda),
    .sda     (sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        ack_ph_q, ack_ph_d;
  logic        sda_t_q, sda_t_d;
  logic        busy_q, busy_d;
  logic [15:0] out_q, out_d, pol_q, pol_d, cfg_q, cfg_d;
  logic [15:0] pins_q, oe_q;
  logic [7:0]  byte_in, rd_byte;
  logic [2:0]  tx_idx;
  logic        last_bit;

  assign byte_in  = {shift_q, sda};
  assign rd_byte  = reg_read(ptr_q, i_pins, out_q, pol_q, cfg_q);
  assign tx_idx   = 3'd7 - bit_cnt_q[2:0];
  assign last_bit = (bit_cnt_q == 4'd7);

  // ack_ph marks that the fall opening the 9th bit slot has been seen, so the
  // next fall closes it.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    ack_ph_d  = ack_ph_q;
    sda_t_d   = sda_t_q;
    busy_d    = busy_q;
    out_d     = out_q;
    pol_d     = pol_q;
    cfg_d     = cfg_q;

    if (start) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      ack_ph_d  = 1'b0;
      sda_t_d   = 1'b1;
      busy_d    = 1'b1;
    end else if (stop) begin
      state_d  = IDLE;
      ack_ph_d = 1'b0;
      sda_t_d  = 1'b1;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              rw_d    = sda;
              state_d = (byte_in[7:1] == SADR) ? ADDR_ACK : IGNORE;
            end
          end
        end

        REG: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              ptr_d   = byte_in[2:0];
              state_d = REG_ACK;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              case (ptr_q)
                REG_IN0, REG_IN1: ;
                REG_OUT0: out_d[7:0]  = byte_in;
                REG_OUT1: out_d[15:8] = byte_in;
                REG_POL0: pol_d[7:0]  = byte_in;
                REG_POL1: pol_d[15:8] = byte_in;
                REG_CFG0: cfg_d[7:0]  = byte_in;
                REG_CFG1: cfg_d[15:8] = byte_in;
              endcase
              ptr_d   = ptr_q ^ 3'b001;
              state_d = WR_ACK;
            end
          end
        end

        ADDR_ACK, REG_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_t_d  = 1'b0;
              ack_ph_d = 1'b1;
            end else begin
              ack_ph_d  = 1'b0;
              bit_cnt_d = '0;
              sda_t_d   = 1'b1;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d = RD_DATA;
                tx_d    = rd_byte;
                sda_t_d = rd_byte[7];
              end else if (state_q == ADDR_ACK) begin
                state_d = REG;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              state_d  = RD_ACK;
              ack_ph_d = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            sda_t_d = tx_q[tx_idx];
          end
        end

        RD_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_t_d  = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              // next byte is captured here, at the fall that begins its MSB
              state_d   = RD_DATA;
              tx_d      = rd_byte;
              sda_t_d   = rd_byte[7];
              bit_cnt_d = '0;
              ack_ph_d  = 1'b0;
            end
          end else if (scl_rise && ack_ph_q) begin
            if (sda) begin
              state_d  = IGNORE;
              sda_t_d  = 1'b1;
              ack_ph_d = 1'b0;
            end else begin
              ptr_d = ptr_q ^ 3'b001;
            end
          end
        end

        IGNORE:  sda_t_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ack_ph_q  <= 1'b0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      out_q     <= OUT_RST;
      pol_q     <= POL_RST;
      cfg_q     <= CFG_RST;
      pins_q    <= OUT_RST;
      oe_q      <= ~CFG_RST;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      ack_ph_q  <= ack_ph_d;
      sda_t_q   <= sda_t_d;
      busy_q    <= busy_d;
      out_q     <= out_d;
      pol_q     <= pol_d;
      cfg_q     <= cfg_d;
      // pin-facing copies lag the register write by one clock
      pins_q    <= out_q;
      oe_q      <= ~cfg_q;
    end
  end

  assign o_sda_t = sda_t_q;
  assign o_busy  = busy_q;
  assign o_pins  = pins_q;
  assign o_oe    = oe_q;

endmodule

// File: tb/tb_i2c_expander_target.sv
// Bench for i2c_expander_target: bit-banged I2C master, register-map reference
// model and per-scenario checks, including randomized write/read-back rounds.
module tb_i2c_expander_target;

  localparam int Q = 12;  // clocks per quarter SCL period

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] pins  = 16'h0000;
  logic        sda_bus, sda_t, busy;
  logic [15:0] pins_o, oe;

  assign sda_bus = sda_m & sda_t;

  i2c_expander_target #(
    .SADR       (7'b0100_000),
    .CLK_RATE_HZ(16_000_000)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_scl  (scl_m),
    .i_sda  (sda_bus),
    .o_sda_t(sda_t),
    .i_pins (pins),
    .o_pins (pins_o),
    .o_oe   (oe),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Free-running bus monitors: clocks spent pulling SDA low, and SDA changes while SCL is high.
  int   low_cnt = 0;
  int   viol = 0;
  logic sda_t_prev = 1'b1;
  logic scl_prev = 1'b1;
  always @(posedge clk) begin
    sda_t_prev <= sda_t;
    scl_prev   <= scl_m;
    if (sda_t === 1'b0) low_cnt <= low_cnt + 1;
    if (!rst && scl_m && scl_prev && (sda_t !== sda_t_prev)) viol <= viol + 1;
  end

  // Reference model of the register map.
  logic [15:0] m_out, m_pol, m_cfg;
  logic [2:0]  m_ptr;
  logic [7:0]  wbuf[4];
  logic [7:0]  rbuf[4];

  task automatic model_reset();
    m_out = 16'hFFFF;
    m_pol = 16'h0000;
    m_cfg = 16'hFFFF;
    m_ptr = 3'd0;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] w, input int hi, input logic [7:0] d);
    return (hi != 0) ? {d, w[7:0]} : {w[15:8], d};
  endfunction

  task automatic model_write(input logic [7:0] d);
    int grp = int'(m_ptr) / 2;
    int hi = int'(m_ptr) % 2;
    if (grp == 1) m_out = merge(m_out, hi, d);
    if (grp == 2) m_pol = merge(m_pol, hi, d);
    if (grp == 3) m_cfg = merge(m_cfg, hi, d);
    m_ptr = m_ptr ^ 3'd1;
  endtask

  task automatic model_write_txn(input logic [7:0] pb, input int n);
    m_ptr = pb[2:0];
    for (int i = 0; i < n; i++) model_write(wbuf[i]);
  endtask

  function automatic logic [7:0] ref_read(input logic [2:0] p);
    logic [15:0] w;
    case (int'(p) / 2)
      0:       w = pins ^ m_pol;
      1:       w = m_out;
      2:       w = m_pol;
      default: w = m_cfg;
    endcase
    return ((int'(p) % 2) == 1) ? w[15:8] : w[7:0];
  endfunction

  // Bit-level master.
  task automatic hold();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; hold();
    scl_m = 1'b1; hold();
    sda_m = 1'b0; hold();
    scl_m = 1'b0; hold();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; hold();
    scl_m = 1'b1; hold();
    sda_m = 1'b1; hold();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; hold();
    scl_m = 1'b1; hold(); hold();
    scl_m = 1'b0; hold();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; hold();
    scl_m = 1'b1; hold();
    b = sda_bus; hold();
    scl_m = 1'b0; hold();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  task automatic write_txn(input logic [7:0] pb, input int n, output int nacks);
    logic a;
    nacks = 0;
    bus_start();
    send_byte(8'h40, a); if (a !== 1'b0) nacks++;
    send_byte(pb, a);    if (a !== 1'b0) nacks++;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a);
      if (a !== 1'b0) nacks++;
    end
    bus_stop();
  endtask

  // Leaves the bus after the final NACK, without a STOP.
  task automatic read_txn(input logic [7:0] pb, input int n, output int nacks);
    logic a;
    logic [7:0] d;
    nacks = 0;
    bus_start();
    send_byte(8'h40, a); if (a !== 1'b0) nacks++;
    send_byte(pb, a);    if (a !== 1'b0) nacks++;
    bus_start();
    send_byte(8'h41, a); if (a !== 1'b0) nacks++;
    for (int i = 0; i < n; i++) begin
      recv_byte(d, (i == n - 1));
      rbuf[i] = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    hold();
    checks++; if (sda_t !== 1'b1) $display("FAIL reset_sda_t: got %b expected 1", sda_t); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (pins_o !== m_out) $display("FAIL reset_o_pins: got %h expected %h", pins_o, m_out); else passes++;
    checks++; if (oe !== ~m_cfg) $display("FAIL reset_o_oe: got %h expected %h", oe, ~m_cfg); else passes++;
  endtask

  task automatic test_cfg_write();
    int nacks;
    wbuf[0] = 8'hEA; wbuf[1] = 8'h7F;
    write_txn(8'h06, 2, nacks);
    model_write_txn(8'h06, 2);
    checks++; if (nacks !== 0) $display("FAIL cfg_acks: got %0d nacks expected 0", nacks); else passes++;
    checks++; if (oe !== ~m_cfg) $display("FAIL cfg_o_oe: got %h expected %h", oe, ~m_cfg); else passes++;
  endtask

  task automatic test_out_write();
    logic a;
    int nacks = 0;
    bus_start();
    send_byte(8'h40, a); if (a !== 1'b0) nacks++;
    checks++; if (busy !== 1'b1) $display("FAIL busy_mid: got %b expected 1", busy); else passes++;
    send_byte(8'h02, a); if (a !== 1'b0) nacks++;
    send_byte(8'h15, a); if (a !== 1'b0) nacks++;
    for (int i = 7; i >= 0; i--) send_bit(i == 7);
    wbuf[0] = 8'h15; wbuf[1] = 8'h80;
    model_write_txn(8'h02, 2);
    checks++; if (pins_o !== m_out) $display("FAIL out_o_pins: got %h expected %h", pins_o, m_out); else passes++;
    recv_bit(a); if (a !== 1'b0) nacks++;
    bus_stop();
    checks++; if (nacks !== 0) $display("FAIL out_acks: got %0d nacks expected 0", nacks); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_after_stop: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_read_inputs();
    int nacks;
    int lc;
    logic [7:0] exp0, exp1;
    pins = 16'hA5C3;
    wbuf[0] = 8'hFF; wbuf[1] = 8'h00;
    write_txn(8'h04, 2, nacks);
    model_write_txn(8'h04, 2);
    read_txn(8'h00, 2, nacks);
    m_ptr = 3'd0;
    exp0 = ref_read(m_ptr);
    m_ptr = m_ptr ^ 3'd1;
    exp1 = ref_read(m_ptr);
    lc = low_cnt;
    hold(); hold();
    checks++; if (sda_t !== 1'b1) $display("FAIL rd_release: got %b expected 1", sda_t); else passes++;
    bus_stop();
    checks++; if (low_cnt !== lc) $display("FAIL rd_release_hold: got %0d low clocks expected 0", low_cnt - lc); else passes++;
    checks++; if (nacks !== 0) $display("FAIL rd_acks: got %0d nacks expected 0", nacks); else passes++;
    checks++; if (rbuf[0] !== exp0) $display("FAIL rd_byte0: got %h expected %h", rbuf[0], exp0); else passes++;
    checks++; if (rbuf[1] !== exp1) $display("FAIL rd_byte1: got %h expected %h", rbuf[1], exp1); else passes++;
  endtask

  task automatic test_other_addr();
    logic a;
    int nacks = 0;
    int lc = low_cnt;
    bus_start();
    send_byte(8'h42, a); if (a === 1'b1) nacks++;
    send_byte(8'h02, a); if (a === 1'b1) nacks++;
    send_byte(8'h55, a); if (a === 1'b1) nacks++;
    bus_stop();
    checks++; if (nacks !== 3) $display("FAIL other_nacks: got %0d nacks expected 3", nacks); else passes++;
    checks++; if (low_cnt !== lc) $display("FAIL other_sda_low: got %0d low clocks expected 0", low_cnt - lc); else passes++;
    checks++; if (pins_o !== m_out) $display("FAIL other_o_pins: got %h expected %h", pins_o, m_out); else passes++;
  endtask

  task automatic test_partial_stop();
    logic a;
    logic [7:0] d;
    logic [7:0] exp;
    bus_start();
    send_byte(8'h40, a);
    send_byte(8'h02, a);
    m_ptr = 3'd2;
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    bus_stop();
    checks++; if (pins_o !== m_out) $display("FAIL partial_o_pins: got %h expected %h", pins_o, m_out); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL partial_busy: got %b expected 0", busy); else passes++;
    // read with no pointer write uses the persisted pointer
    bus_start();
    send_byte(8'h41, a);
    recv_byte(d, 1'b1);
    bus_stop();
    exp = ref_read(m_ptr);
    checks++; if (d !== exp) $display("FAIL persist_ptr_read: got %h expected %h", d, exp); else passes++;
  endtask

  task automatic test_random();
    int nacks;
    int n;
    logic [7:0] pb, exp0, exp1;
    for (int it = 0; it < 5; it++) begin
      pins = 16'($urandom);
      pb = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_txn(pb, n, nacks);
      model_write_txn(pb, n);
      checks++; if (nacks !== 0) $display("FAIL rnd_wr_acks[%0d]: got %0d expected 0", it, nacks); else passes++;
      checks++; if (pins_o !== m_out) $display("FAIL rnd_o_pins[%0d]: got %h expected %h", it, pins_o, m_out); else passes++;
      checks++; if (oe !== ~m_cfg) $display("FAIL rnd_o_oe[%0d]: got %h expected %h", it, oe, ~m_cfg); else passes++;
      read_txn(pb, 2, nacks);
      bus_stop();
      m_ptr = pb[2:0];
      exp0 = ref_read(m_ptr);
      m_ptr = m_ptr ^ 3'd1;
      exp1 = ref_read(m_ptr);
      checks++; if (rbuf[0] !== exp0) $display("FAIL rnd_rd0[%0d]: got %h expected %h", it, rbuf[0], exp0); else passes++;
      checks++; if (rbuf[1] !== exp1) $display("FAIL rnd_rd1[%0d]: got %h expected %h", it, rbuf[1], exp1); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [7:0] d = 8'($urandom);
    bus_start();
    send_byte(8'h40, a);
    send_byte(8'h02, a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda_m = 1'b1;
    checks++; if (sda_t !== 1'b0) $display("FAIL mid_ack_driven: got %b expected 0", sda_t); else passes++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (sda_t !== 1'b1) $display("FAIL mid_reset_release: got %b expected 1", sda_t); else passes++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    scl_m = 1'b1; hold();
    bus_stop();
    checks++; if (pins_o !== m_out) $display("FAIL mid_o_pins: got %h expected %h", pins_o, m_out); else passes++;
    checks++; if (oe !== ~m_cfg) $display("FAIL mid_o_oe: got %h expected %h", oe, ~m_cfg); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_sda_stability();
    checks++; if (viol !== 0) $display("FAIL sda_while_scl_high: got %0d changes expected 0", viol); else passes++;
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_out_write();
    test_read_inputs();
    test_other_addr();
    test_partial_stop();
    test_random();
    test_reset_mid();
    test_sda_stability();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2c_expander_target.md
I2C_EXPANDER_TARGET -- requirements
Module: i2c_expander_target

Interface
REQ-001 Parameter SADR, default 7'b0100_000, is the 7-bit target address that the block answers to.
REQ-002 Parameter CLK_RATE_HZ, default 16_000_000, is the i_clk rate; it is used only for the glitch-filter length.
REQ-003 Port i_clk, input, 1 bit: the single clock for all logic.
REQ-004 Port i_reset, input, 1 bit: reset that is synchronous and active-high.
REQ-005 Port i_scl, input, 1 bit: raw SCL pad value.
REQ-006 Port i_sda, input, 1 bit: raw SDA pad value.
REQ-007 Port o_sda_t, output, 1 bit: SDA tristate control; 1 releases the line, 0 drives it low.
REQ-008 Port i_pins, input, 16 bits: GPIO input levels; bits [7:0] are port 0 and bits [15:8] are port 1.
REQ-009 Port o_pins, output, 16 bits: output register value.
REQ-010 Port o_oe, output, 16 bits: bitwise inverse of the configuration register (1 = pin driven).
REQ-011 Port o_busy, output, 1 bit: high between a detected START and the next STOP.

Function
REQ-012 SCL and SDA pass through a 2-FF synchronizer and a 3-sample majority filter; all edge detection uses the filtered signals.
REQ-013 START: filtered SDA falls while SCL is high. STOP: filtered SDA rises while SCL is high. Both are honored in any state, and a repeated START restarts address reception.
REQ-014 Data is sampled on the filtered SCL rising edge. o_sda_t changes only within 4 clocks after a filtered SCL falling edge; SDA is never changed while SCL is high.
REQ-015 State machine states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 IDLE -> ADDR on START. After 8 bits, ADDR -> ADDR_ACK on an address match, otherwise -> IGNORE, which releases SDA until the next START or STOP.
REQ-017 After ADDR_ACK: with R/W=0 go to REG; with R/W=1 go to RD_DATA, loading the read byte from the current pointer.
REQ-018 REG receives the pointer byte; pointer bits [2:0] are kept and bits [7:3] are ignored. The byte is ACKed and followed by REG_ACK -> WR_DATA.
REQ-019 In WR_DATA each byte is written to the pointed register at the 8th SCL rise and ACKed. The pointer then toggles bit 0, so writes alternate within the pair (0<->1, 2<->3, 4<->5, 6<->7).
REQ-020 Register map: 0/1 input (read-only; writes are ACKed and discarded), 2/3 output, 4/5 polarity inversion, 6/7 configuration.
REQ-021 Input register read value = i_pins byte XOR polarity byte, captured at the SCL falling edge that begins that byte's MSB.
REQ-022 RD_ACK samples the master's ACK bit. ACK=0 toggles pointer bit 0 and loads the next byte. ACK=1 (NACK) goes to IGNORE and releases SDA.
REQ-023 A STOP or START in the middle of a byte discards the partial byte; registers already written keep their values.
REQ-024 The pointer persists across transactions, so a read without a preceding pointer write uses the last pointer.
REQ-025 o_pins and o_oe update 1 clock after the register write.
REQ-026 There is no clock stretching: SCL is never driven.

Reset
REQ-027 On i_reset, state = IDLE, o_sda_t = 1, o_busy = 0, and pointer = 0.
REQ-028 On i_reset, output registers = 16'hFFFF, polarity = 16'h0000, configuration = 16'hFFFF; therefore o_pins = 16'hFFFF and o_oe = 16'h0000.
REQ-029 Reset asserted mid-transaction releases SDA on the next clock and ignores the bus until the next START.

Structure
REQ-030 Register addresses 0-7, register reset values and the state encoding are defined in the shared package user_io_pkg.
REQ-031 The synchronizer, majority filter and START/STOP/edge detector form one sub-module, i2c_line_cond, instantiated once.

Verification
REQ-032 Write 0x40 (addr+W), 0x06, 0xEA, 0x7F -> ACK on every byte; o_oe = 16'h8015.
REQ-033 Write 0x40, 0x02, 0x15, 0x80 -> o_pins = 16'h8015 one clock after the last data bit.
REQ-034 With i_pins = 16'hA5C3 and polarity set to 16'h00FF, write 0x40, 0x00, repeated START, 0x41, then read 2 bytes with ACK then NACK -> bytes 0x3C and 0xA5 are returned and SDA is released after the NACK.
REQ-035 Address 0x42 (another target) -> no ACK, SDA stays released for the whole transfer, and no registers change.
REQ-036 STOP after 4 bits of a data byte to register 2 -> register 2 is unchanged and the FSM returns to IDLE.
REQ-037 Assert i_reset while the block is driving an ACK low -> o_sda_t = 1 on the next clock and all registers return to their reset values.
